// File: rtl/conv_load_sequencer.sv
// rtl/conv_load_sequencer.sv - phase controller sequencing filter/sample loads and convolution start
module conv_load_sequencer #(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int FRAME_CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        reuse_f,
    input  logic                        conv_done,
    output logic                        wr_en_f,
    output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
    output logic                        wr_en_x,
    output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x,
    output logic                        conv_start,
    output logic                        busy,
    output logic [FRAME_CNT_WIDTH-1:0]  frame_cnt
);

    localparam logic [1:0] LOAD_F = 2'd0;
    localparam logic [1:0] LOAD_X = 2'd1;
    localparam logic [1:0] CONV   = 2'd2;

    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);

    logic [1:0]                  state;
    logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
    logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;
    logic                        f_loaded;
    logic                        hs;

    // Everything below is decoded from registered state so memories see
    // write enable and address in the same cycle as the handshake.
    assign s_ready    = (state == LOAD_F) || (state == LOAD_X);
    assign hs         = s_valid && s_ready;
    assign wr_en_f    = hs && (state == LOAD_F);
    assign wr_en_x    = hs && (state == LOAD_X);
    assign wr_addr_f  = f_cnt;
    assign wr_addr_x  = x_cnt;
    assign conv_start = (state == CONV);
    assign busy       = (state == CONV);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD_F;
            f_cnt     <= '0;
            x_cnt     <= '0;
            f_loaded  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                LOAD_F: begin
                    if (hs) begin
                        if (f_cnt == F_LAST) begin
                            f_cnt    <= '0;
                            f_loaded <= 1'b1;
                            state    <= LOAD_X;
                        end else begin
                            f_cnt <= f_cnt + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (hs) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            state <= CONV;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= (reuse_f && f_loaded) ? LOAD_X : LOAD_F;
                    end
                end
                default: state <= LOAD_F;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_load_sequencer.sv
// tb/tb_conv_load_sequencer.sv - directed self-checking bench for conv_load_sequencer
module tb_conv_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic       reuse_f;
    logic       conv_done;
    logic       wr_en_f;
    logic [1:0] wr_addr_f;
    logic       wr_en_x;
    logic [2:0] wr_addr_x;
    logic       conv_start;
    logic       busy;
    logic [7:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int f_log[$];
    int x_log[$];
    int bad_wr   = 0;

    conv_load_sequencer #(
        .F_MEM_SIZE(4), .X_MEM_SIZE(8), .F_MEM_ADDR_WIDTH(2),
        .X_MEM_ADDR_WIDTH(3), .FRAME_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .reuse_f(reuse_f), .conv_done(conv_done),
        .wr_en_f(wr_en_f), .wr_addr_f(wr_addr_f),
        .wr_en_x(wr_en_x), .wr_addr_x(wr_addr_x),
        .conv_start(conv_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Write monitor sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (wr_en_f) f_log.push_back(int'(wr_addr_f));
        if (wr_en_x) x_log.push_back(int'(wr_addr_x));
        if ((wr_en_f || wr_en_x) && !s_valid) bad_wr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Presents words until n are accepted; optional ~50% valid bubbles
    task automatic feed(input int n, input bit bubbles, output bit timed_out);
        int got = 0;
        int cyc = 0;
        timed_out = 1'b0;
        while (got < n) begin
            s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) got++;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_done(input bit r);
        conv_done = 1'b1;
        reuse_f   = r;
        tick();
        conv_done = 1'b0;
        reuse_f   = ~r;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_ready !== 1'b1 || conv_start !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0
            || wr_en_f !== 1'b0 || wr_addr_f !== 2'd0 || wr_addr_x !== 3'd0) begin
            failures++;
            $display("FAIL reset: s_ready=%b conv_start=%b busy=%b frame_cnt=%0d addr_f=%0d addr_x=%0d expected 1 0 0 0 0 0",
                     s_ready, conv_start, busy, frame_cnt, wr_addr_f, wr_addr_x);
        end
    endtask

    task automatic test_full_frame();
        bit to;
        int err;
        f_log.delete(); x_log.delete();
        feed(4, 1'b0, to);
        err = 0;
        foreach (f_log[i]) if (f_log[i] != i) err++;
        checks++;
        if (to || f_log.size() != 4 || err != 0 || x_log.size() != 0) begin
            failures++;
            $display("FAIL full_f_load: f_writes=%0d bad_addr=%0d x_writes=%0d timeout=%0b expected 4 0 0 0",
                     f_log.size(), err, x_log.size(), to);
        end
        checks++;
        if (conv_start !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_f_load: conv_start=%b s_ready=%b expected 0 1", conv_start, s_ready);
        end
        feed(8, 1'b0, to);
        err = 0;
        foreach (x_log[i]) if (x_log[i] != i) err++;
        checks++;
        if (to || x_log.size() != 8 || err != 0 || f_log.size() != 4) begin
            failures++;
            $display("FAIL full_x_load: x_writes=%0d bad_addr=%0d f_writes=%0d timeout=%0b expected 8 0 4 0",
                     x_log.size(), err, f_log.size(), to);
        end
        checks++;
        if (conv_start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL conv_entry: conv_start=%b busy=%b s_ready=%b expected 1 1 0", conv_start, busy, s_ready);
        end
    endtask

    task automatic test_reuse();
        bit to;
        int err;
        pulse_done(1'b1);
        checks++;
        if (frame_cnt !== 8'd1 || conv_start !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reuse_done: frame_cnt=%0d conv_start=%b s_ready=%b expected 1 0 1", frame_cnt, conv_start, s_ready);
        end
        f_log.delete(); x_log.delete();
        feed(8, 1'b0, to);
        err = 0;
        foreach (x_log[i]) if (x_log[i] != i) err++;
        checks++;
        if (to || f_log.size() != 0 || x_log.size() != 8 || err != 0 || conv_start !== 1'b1) begin
            failures++;
            $display("FAIL reuse_load: f_writes=%0d x_writes=%0d bad_addr=%0d conv_start=%b expected 0 8 0 1",
                     f_log.size(), x_log.size(), err, conv_start);
        end
        pulse_done(1'b0);
        f_log.delete(); x_log.delete();
        feed(4, 1'b0, to);
        err = 0;
        foreach (f_log[i]) if (f_log[i] != i) err++;
        checks++;
        if (to || frame_cnt !== 8'd2 || f_log.size() != 4 || err != 0 || x_log.size() != 0) begin
            failures++;
            $display("FAIL no_reuse_load: frame_cnt=%0d f_writes=%0d bad_addr=%0d x_writes=%0d expected 2 4 0 0",
                     frame_cnt, f_log.size(), err, x_log.size());
        end
        feed(8, 1'b0, to);
    endtask

    task automatic test_bubbles();
        bit to1, to2;
        int err;
        pulse_done(1'b0);
        f_log.delete(); x_log.delete();
        bad_wr = 0;
        feed(4, 1'b1, to1);
        feed(8, 1'b1, to2);
        err = 0;
        foreach (f_log[i]) if (f_log[i] != i) err++;
        foreach (x_log[i]) if (x_log[i] != i) err++;
        checks++;
        if (to1 || to2 || f_log.size() != 4 || x_log.size() != 8 || err != 0 || bad_wr != 0) begin
            failures++;
            $display("FAIL bubbles: f_writes=%0d x_writes=%0d bad_addr=%0d stray_writes=%0d expected 4 8 0 0",
                     f_log.size(), x_log.size(), err, bad_wr);
        end
        checks++;
        if (conv_start !== 1'b1 || frame_cnt !== 8'd3) begin
            failures++;
            $display("FAIL bubbles_conv: conv_start=%b frame_cnt=%0d expected 1 3", conv_start, frame_cnt);
        end
    endtask

    task automatic test_done_ignored();
        bit to;
        int err;
        pulse_done(1'b0);
        f_log.delete(); x_log.delete();
        feed(2, 1'b0, to);
        pulse_done(1'b1);
        checks++;
        if (frame_cnt !== 8'd4 || s_ready !== 1'b1 || wr_addr_f !== 2'd2 || conv_start !== 1'b0) begin
            failures++;
            $display("FAIL done_in_load_f: frame_cnt=%0d s_ready=%b addr_f=%0d conv_start=%b expected 4 1 2 0",
                     frame_cnt, s_ready, wr_addr_f, conv_start);
        end
        feed(2, 1'b0, to);
        feed(3, 1'b0, to);
        pulse_done(1'b0);
        checks++;
        if (frame_cnt !== 8'd4 || s_ready !== 1'b1 || wr_addr_x !== 3'd3 || f_log.size() != 4) begin
            failures++;
            $display("FAIL done_in_load_x: frame_cnt=%0d s_ready=%b addr_x=%0d f_writes=%0d expected 4 1 3 4",
                     frame_cnt, s_ready, wr_addr_x, f_log.size());
        end
        feed(5, 1'b0, to);
        err = 0;
        foreach (f_log[i]) if (f_log[i] != i) err++;
        foreach (x_log[i]) if (x_log[i] != i) err++;
        checks++;
        if (to || x_log.size() != 8 || err != 0 || conv_start !== 1'b1) begin
            failures++;
            $display("FAIL done_ignored_seq: x_writes=%0d bad_addr=%0d conv_start=%b expected 8 0 1",
                     x_log.size(), err, conv_start);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int err;
        pulse_done(1'b0);
        feed(2, 1'b0, to);
        do_reset();
        checks++;
        if (wr_addr_f !== 2'd0 || frame_cnt !== 8'd0 || conv_start !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_load_f: addr_f=%0d frame_cnt=%0d conv_start=%b s_ready=%b expected 0 0 0 1",
                     wr_addr_f, frame_cnt, conv_start, s_ready);
        end
        f_log.delete(); x_log.delete();
        feed(4, 1'b0, to);
        feed(8, 1'b0, to);
        err = 0;
        foreach (f_log[i]) if (f_log[i] != i) err++;
        checks++;
        if (to || f_log.size() != 4 || err != 0 || conv_start !== 1'b1) begin
            failures++;
            $display("FAIL reload_after_reset: f_writes=%0d bad_addr=%0d conv_start=%b expected 4 0 1",
                     f_log.size(), err, conv_start);
        end
        reuse_f = 1'b1;
        do_reset();
        checks++;
        if (conv_start !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_in_conv: conv_start=%b busy=%b s_ready=%b frame_cnt=%0d expected 0 0 1 0",
                     conv_start, busy, s_ready, frame_cnt);
        end
        f_log.delete(); x_log.delete();
        feed(4, 1'b0, to);
        checks++;
        if (f_log.size() != 4 || x_log.size() != 0) begin
            failures++;
            $display("FAIL f_reload_after_conv_reset: f_writes=%0d x_writes=%0d expected 4 0", f_log.size(), x_log.size());
        end
        feed(8, 1'b0, to);
    endtask

    task automatic test_wrap();
        bit to;
        for (int i = 1; i <= 256; i++) begin
            pulse_done(1'b1);
            if (i == 255) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL frame_cnt_255: got %0d expected 255", frame_cnt);
                end
            end
            if (i < 256) feed(8, 1'b0, to);
        end
        checks++;
        if (frame_cnt !== 8'd0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_cnt_wrap: frame_cnt=%0d s_ready=%b expected 0 1", frame_cnt, s_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        reuse_f   = 1'b0;
        conv_done = 1'b0;
        #1;
        test_reset();
        test_full_frame();
        test_reuse();
        test_bubbles();
        test_done_ignored();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
